// File: rtl/aespim_decrypt.sv
// Column-serial AES-128 inverse cipher: takes ciphertext plus round-10 key as a word stream,
// rolls the key schedule backwards one round at a time and decrypts one column per cycle.

module bSbox (
    input  logic       inv,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] acc;
        p   = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p   = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] pre;
    logic [7:0] rec;

    always_comb begin
        pre  = inv ? inv_affine(din) : din;
        rec  = gf_inv(pre);
        dout = inv ? rec : affine(rec);
    end
endmodule

module aespim_decrypt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] data_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] data_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {S_LOAD, S_KEY, S_COL, S_OUT} state_t;

    state_t      fsm;
    logic [2:0]  n;
    logic [3:0]  r;
    logic [1:0]  c;
    logic [31:0] st  [4];
    logic [31:0] sh  [4];
    logic [31:0] key [4];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = a[7:0];
        a1 = a[15:8];
        a2 = a[23:16];
        a3 = a[31:24];
        b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        return {b3, b2, b1, b0};
    endfunction

    // Rcon of the round whose key is being undone (round r+1)
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic        sbox_inv;
    logic [31:0] sb_in;
    logic [31:0] sb_out;
    logic [31:0] w0n, w1n, w2n, w3n;
    logic [31:0] col_pre;
    logic [31:0] col_res;

    // The four S-boxes serve RotWord(w3') in KEY and the InvShiftRows'd column in COL
    always_comb begin
        w3n      = key[3] ^ key[2];
        w2n      = key[2] ^ key[1];
        w1n      = key[1] ^ key[0];
        sbox_inv = (fsm == S_COL);
        sb_in    = sbox_inv ? {st[c - 2'd3][31:24], st[c - 2'd2][23:16], st[c - 2'd1][15:8], st[c][7:0]}
                            : {w3n[7:0], w3n[31:8]};
        w0n      = key[0] ^ sb_out ^ {24'h0, rcon(r)};
        col_pre  = sb_out ^ key[c];
        col_res  = (r == 4'd0) ? col_pre : inv_mix(col_pre);
    end

    for (genvar j = 0; j < 4; j++) begin : g_sbox
        bSbox u_sbox (
            .inv  (sbox_inv),
            .din  (sb_in[8*j +: 8]),
            .dout (sb_out[8*j +: 8])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm     <= S_LOAD;
            n       <= 3'd0;
            r       <= 4'd0;
            c       <= 2'd0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            data_o  <= 32'h0;
            busy_o  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                st[i]  <= 32'h0;
                sh[i]  <= 32'h0;
                key[i] <= 32'h0;
            end
        end else begin
            case (fsm)
                S_LOAD: begin
                    if (valid_i) begin
                        if (!n[2]) begin
                            st[n[1:0]] <= data_i;
                        end else begin
                            key[n[1:0]] <= data_i;
                            st[n[1:0]]  <= st[n[1:0]] ^ data_i;
                        end
                        if (n == 3'd7) begin
                            n       <= 3'd0;
                            r       <= 4'd9;
                            fsm     <= S_KEY;
                            ready_o <= 1'b0;
                            busy_o  <= 1'b1;
                        end else begin
                            n <= n + 3'd1;
                        end
                    end
                end
                S_KEY: begin
                    key[0] <= w0n;
                    key[1] <= w1n;
                    key[2] <= w2n;
                    key[3] <= w3n;
                    c      <= 2'd0;
                    fsm    <= S_COL;
                end
                S_COL: begin
                    sh[c] <= col_res;
                    if (c != 2'd3) begin
                        c <= c + 2'd1;
                    end else begin
                        // Columns 0..2 were parked in the shadow so InvShiftRows kept reading the old round
                        st[0] <= sh[0];
                        st[1] <= sh[1];
                        st[2] <= sh[2];
                        st[3] <= col_res;
                        c     <= 2'd0;
                        if (r != 4'd0) begin
                            r   <= r - 4'd1;
                            fsm <= S_KEY;
                        end else begin
                            fsm     <= S_OUT;
                            n       <= 3'd0;
                            valid_o <= 1'b1;
                            data_o  <= sh[0];
                            busy_o  <= 1'b0;
                        end
                    end
                end
                S_OUT: begin
                    if (ready_i) begin
                        if (n == 3'd3) begin
                            fsm     <= S_LOAD;
                            n       <= 3'd0;
                            valid_o <= 1'b0;
                            data_o  <= 32'h0;
                            ready_o <= 1'b1;
                        end else begin
                            n      <= n + 3'd1;
                            data_o <= st[n[1:0] + 2'd1];
                        end
                    end
                end
                default: fsm <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_aespim_decrypt.sv
// Scoreboard bench for aespim_decrypt: FIPS-197 vectors, handshake stress, reset abort,
// back-to-back blocks and loopback through a behavioural AES-128 encryptor.

module tb_aespim_decrypt;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic        busy_o;

    aespim_decrypt dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] C1_CT = {32'h5ac5b470, 32'h80b7cdd8, 32'h30047b6a, 32'hd8e0c469};
    localparam logic [127:0] C1_K  = {32'hc5302b4d, 32'h8ba707f3, 32'h174a94e3, 32'h7f1d1113};
    localparam logic [127:0] C1_PT = {32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100};
    localparam logic [127:0] B_CT  = {32'h320b6a19, 32'h978511dc, 32'hfb09dc02, 32'h1d842539};
    localparam logic [127:0] B_K   = {32'ha60c63b6, 32'hc80c3fe1, 32'h8925eec9, 32'ha8f914d0};
    localparam logic [127:0] B_PT  = {32'h340737e0, 32'ha2983131, 32'h8d305a88, 32'ha8f64332};

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          rise_cyc = 0;
    int          out_cnt = 0;
    bit          stall_mode = 0;
    bit          toggle_mode = 0;
    logic [31:0] q [$];
    logic [7:0]  sbox [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference S-box from the generator-3 walk of GF(2^8)
    task automatic build_sbox();
        logic [7:0] p, qq, x;
        p  = 8'h01;
        qq = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p  = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            qq = qq ^ {qq[6:0], 1'b0};
            qq = qq ^ {qq[5:0], 2'b0};
            qq = qq ^ {qq[3:0], 4'b0};
            if (qq[7]) qq = qq ^ 8'h09;
            x = qq ^ {qq[6:0], qq[7]} ^ {qq[5:0], qq[7:6]} ^ {qq[4:0], qq[7:5]} ^ {qq[3:0], qq[7:4]};
            sbox[p] = x ^ 8'h63;
        end
        sbox[0] = 8'h63;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] o;
        for (int j = 0; j < 4; j++) o[8*j +: 8] = sbox[w[8*j +: 8]];
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[7:0]; a1 = a[15:8]; a2 = a[23:16]; a3 = a[31:24];
        return {xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3),
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3};
    endfunction

    task automatic aes_encrypt(input logic [127:0] k, input logic [127:0] pt,
                               output logic [127:0] ct, output logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] s [4];
        logic [31:0] ns [4];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[7:0], t[31:8]}) ^ {24'h0, rc};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int c = 0; c < 4; c++) s[c] = pt[32*c +: 32] ^ w[c];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    ns[c][8*rr +: 8] = sbox[s[(c + rr) % 4][8*rr +: 8]];
            for (int c = 0; c < 4; c++)
                s[c] = ((rnd < 10) ? mix_col(ns[c]) : ns[c]) ^ w[4*rnd + c];
        end
        for (int c = 0; c < 4; c++) begin
            ct[32*c +: 32]  = s[c];
            k10[32*c +: 32] = w[40 + c];
        end
    endtask

    task automatic push_block(input logic [127:0] pt);
        for (int c = 0; c < 4; c++) q.push_back(pt[32*c +: 32]);
    endtask

    task automatic send_block(input logic [127:0] ct, input logic [127:0] k, input bit gaps);
        logic [255:0] words;
        bit           acc;
        int           guard;
        words = {k, ct};
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                valid_i = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            valid_i = 1'b1;
            data_i  = words[32*i +: 32];
            acc     = 1'b0;
            guard   = 0;
            while (!acc && guard < 3000) begin
                @(negedge clk);
                acc = ready_o;
                @(posedge clk); #1;
                guard++;
            end
            if (!acc) begin
                n_cmp++; n_err++;
                $display("FAIL load_timeout: word %0d not accepted, ready_o %b", i, ready_o);
                valid_i = 1'b0;
                return;
            end
        end
        acc_cyc = cyc;
        valid_i = 1'b0;
        data_i  = 32'h0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (q.size() != 0 && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        if (q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL out_timeout: %0d words outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    // Consumer side: hold ready_i low for 7 cycles of each presented word when stalling
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!stall_mode) ready_i = 1'b1;
            else if (valid_o && stall_cnt < 7) begin ready_i = 1'b0; stall_cnt++; end
            else if (valid_o) begin ready_i = 1'b1; stall_cnt = 0; end
            else ready_i = 1'b0;
        end
    end

    // Junk traffic on the input while the core is busy; it must be ignored
    initial begin
        forever begin
            @(posedge clk); #1;
            if (toggle_mode) begin
                if (busy_o) begin valid_i = 1'(($urandom & 1)); data_i = $urandom; end
                else begin valid_i = 1'b0; data_i = 32'h0; end
            end
        end
    end

    // Monitor: pops the scoreboard on every output transfer
    initial begin
        bit          prev_valid, held, chk_rdy;
        logic [31:0] held_data, exp;
        prev_valid = 0; held = 0; chk_rdy = 0; held_data = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 0; held = 0; chk_rdy = 0;
            end else begin
                if (valid_o && !prev_valid) rise_cyc = cyc;
                if (chk_rdy) begin check("ready_after_out", {31'h0, ready_o}, 32'h1); chk_rdy = 0; end
                if (!valid_o) check("data_idle_zero", data_o, 32'h0);
                if (held) begin
                    check("stall_valid_hold", {31'h0, valid_o}, 32'h1);
                    check("stall_data_hold", data_o, held_data);
                end
                held      = valid_o && !ready_i;
                held_data = data_o;
                if (valid_o && ready_i) begin
                    if (q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_out: got %h, required no output", data_o);
                    end else begin
                        exp = q.pop_front();
                        check("plaintext_word", data_o, exp);
                    end
                    out_cnt++;
                    if (out_cnt % 4 == 0) chk_rdy = 1;
                end
                prev_valid = valid_o;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] key, pt, ct, k10;
        build_sbox();
        rst = 1'b1; valid_i = 1'b0; data_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready_o", {31'h0, ready_o}, 32'h1);
        check("reset_valid_o", {31'h0, valid_o}, 32'h0);
        check("reset_data_o", data_o, 32'h0);
        check("reset_busy_o", {31'h0, busy_o}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 C.1 with latency check
        push_block(C1_PT);
        send_block(C1_CT, C1_K, 0);
        wait_done();
        check("latency_c1", rise_cyc - acc_cyc, 32'd50);

        // FIPS-197 Appendix B
        push_block(B_PT);
        send_block(B_CT, B_K, 0);
        wait_done();
        check("latency_b", rise_cyc - acc_cyc, 32'd50);

        // Handshake stress: load gaps, stalled consumer, junk valid_i while busy
        stall_mode = 1;
        push_block(C1_PT);
        send_block(C1_CT, C1_K, 1);
        toggle_mode = 1;
        wait_done();
        toggle_mode = 0;
        valid_i = 1'b0;
        stall_mode = 0;
        check("latency_stress", rise_cyc - acc_cyc, 32'd50);
        @(posedge clk); #1;

        // Reset during COL of round 5, then a fresh block
        send_block(C1_CT, C1_K, 0);
        repeat (22) @(posedge clk);
        #1;
        check("midrun_busy_o", {31'h0, busy_o}, 32'h1);
        check("midrun_ready_o", {31'h0, ready_o}, 32'h0);
        rst = 1'b1;
        #1;
        check("abort_ready_o", {31'h0, ready_o}, 32'h1);
        check("abort_busy_o", {31'h0, busy_o}, 32'h0);
        check("abort_valid_o", {31'h0, valid_o}, 32'h0);
        check("abort_data_o", data_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_block(B_PT);
        send_block(B_CT, B_K, 0);
        wait_done();
        check("latency_after_reset", rise_cyc - acc_cyc, 32'd50);

        // Back-to-back blocks
        push_block(C1_PT);
        push_block(B_PT);
        send_block(C1_CT, C1_K, 0);
        send_block(B_CT, B_K, 0);
        wait_done();

        // Loopback through the reference encryptor
        for (int i = 0; i < 100; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            aes_encrypt(key, pt, ct, k10);
            push_block(pt);
            send_block(ct, k10, (i % 4) == 3);
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
